// File: rtl/ram_pkg.sv
// Definitions shared by the dual-port RAM and its burst master:
// default geometry, controller state encoding and the wrapping address step.
package ram_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_HEIGHT = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned height);
        return (addr >= height - 32'd1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/ram_burst_master_if.sv
// Command, stream and RAM-port signals of the burst master; master modport is
// the controller's view, slave modport is the engine/RAM side.
interface ram_burst_master_if #(
    parameter int unsigned WIDTH = ram_pkg::DEF_WIDTH,
    parameter int unsigned AW    = $clog2(ram_pkg::DEF_HEIGHT) + 1
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [AW-1:0]    cmd_addr;
    logic [AW-1:0]    cmd_len;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic             done;
    logic             err;
    logic [AW-1:0]    ram_addr;
    logic             ram_we;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data, rd_ready, ram_rdata,
        output cmd_ready, wr_ready, rd_valid, rd_data, done, err,
        output ram_addr, ram_we, ram_wdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data, rd_ready, ram_rdata,
        input  cmd_ready, wr_ready, rd_valid, rd_data, done, err,
        input  ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/ram_addr_wrap_cnt.sv
// Loadable burst counter: current word address wrapping at HEIGHT plus the
// remaining-word count, with flags for the final word and an exhausted burst.
module ram_addr_wrap_cnt
    import ram_pkg::*;
#(
    parameter int unsigned HEIGHT = DEF_HEIGHT,
    parameter int unsigned AW     = $clog2(HEIGHT) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [AW-1:0] addr_i,
    input  logic [AW-1:0] len_i,
    input  logic          adv_i,
    output logic [AW-1:0] cur_o,
    output logic          last_o,
    output logic          empty_o
);

    logic [AW-1:0] cur_q, cur_d;
    logic [AW-1:0] rem_q, rem_d;

    always_comb begin
        cur_d = cur_q;
        rem_d = rem_q;
        if (load_i) begin
            cur_d = addr_i;
            rem_d = len_i;
        end else if (adv_i) begin
            cur_d = AW'(wrap_inc(32'(cur_q), HEIGHT));
            rem_d = rem_q - AW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_q <= '0;
            rem_q <= '0;
        end else begin
            cur_q <= cur_d;
            rem_q <= rem_d;
        end
    end

    assign cur_o   = cur_q;
    assign last_o  = (rem_q == AW'(1));
    assign empty_o = (rem_q == '0);

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for one RAM port: streams write beats into the RAM or RAM
// words out through a one-entry output register, with wrapping addresses.
module ram_burst_master
    import ram_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned HEIGHT = DEF_HEIGHT,
    parameter int unsigned AW     = $clog2(HEIGHT) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_burst_master_if.master bus
);

    state_e           state_q;
    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             done_q;
    logic             err_q;

    logic [AW-1:0]    cur;
    logic             last;
    logic             empty;
    logic             cmd_fire;
    logic             cmd_bad;
    logic             wr_beat;
    logic             rd_load;
    logic             rd_take;

    assign cmd_fire = (state_q == IDLE) && bus.cmd_valid;
    assign cmd_bad  = (bus.cmd_addr >= AW'(HEIGHT)) || (bus.cmd_len == '0) ||
                      (bus.cmd_len > AW'(HEIGHT));
    assign wr_beat  = (state_q == WRITE) && bus.wr_valid;
    // Refill the output register whenever it is empty or being drained this cycle.
    assign rd_load  = (state_q == READ) && !empty && (!rd_valid_q || bus.rd_ready);
    assign rd_take  = (state_q == READ) && rd_valid_q && bus.rd_ready;

    ram_addr_wrap_cnt #(
        .HEIGHT (HEIGHT),
        .AW     (AW)
    ) u_cnt (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (cmd_fire && !cmd_bad),
        .addr_i  (bus.cmd_addr),
        .len_i   (bus.cmd_len),
        .adv_i   (wr_beat || rd_load),
        .cur_o   (cur),
        .last_o  (last),
        .empty_o (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        if (cmd_bad) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state_q <= bus.cmd_write ? WRITE : READ;
                        end
                    end
                end
                WRITE: begin
                    if (wr_beat && last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                READ: begin
                    if (rd_load) begin
                        rd_data_q  <= bus.ram_rdata;
                        rd_valid_q <= 1'b1;
                    end else if (rd_take) begin
                        rd_valid_q <= 1'b0;
                    end
                    // done_q is raised on entry so the pulse lines up with the DONE cycle.
                    if (empty && (!rd_valid_q || bus.rd_ready)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.wr_ready  = (state_q == WRITE);
    assign bus.ram_we    = wr_beat;
    assign bus.ram_addr  = ((state_q == WRITE) || (state_q == READ)) ? cur : '0;
    assign bus.ram_wdata = bus.wr_data;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural RAM on the RAM port.
module tb_ram_burst_master;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   we_cnt;

    logic [31:0] mem [0:127] = '{default: 32'hDEAD_BEEF};
    logic [6:0]  wa[$];
    logic [31:0] wd[$];
    logic [31:0] beats[$];

    ram_burst_master_if #(.WIDTH(32), .AW(7)) bus ();

    ram_burst_master #(
        .WIDTH  (32),
        .HEIGHT (48),
        .AW     (7)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, combinational read.
    assign bus.ram_rdata = mem[bus.ram_addr];
    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
            wa.push_back(bus.ram_addr);
            wd.push_back(bus.ram_wdata);
            we_cnt <= we_cnt + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic w, input logic [6:0] a, input logic [6:0] l);
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_valid = 1'b1;
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        logic [4:0]  wpat;
        logic [4:0]  rdy;
        logic [31:0] bp_exp [0:4];
        logic [6:0]  ra [0:2];
        logic [6:0]  rl [0:2];
        int          b;
        int          we0;

        tests = 0;
        fails = 0;
        we_cnt = 0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;
        repeat (3) cyc();

        // Reset state
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_wr_ready",  64'(bus.wr_ready),  64'd0);
        chk("rst_rd_valid",  64'(bus.rd_valid),  64'd0);
        chk("rst_rd_data",   64'(bus.rd_data),   64'd0);
        chk("rst_done",      64'(bus.done),      64'd0);
        chk("rst_err",       64'(bus.err),       64'd0);
        chk("rst_ram_we",    64'(bus.ram_we),    64'd0);
        chk("rst_ram_addr",  64'(bus.ram_addr),  64'd0);
        rst_n = 1'b1;
        cyc();

        // Write burst addr=5 len=4, A0..A3 back to back
        we0 = we_cnt;
        cmd(1'b1, 7'd5, 7'd4);
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'(32'hA0 + i);
            #1;
            chk("wr_ready", 64'(bus.wr_ready), 64'd1);
            chk("wr_we",    64'(bus.ram_we),   64'd1);
            chk("wr_addr",  64'(bus.ram_addr), 64'(5 + i));
            chk("wr_wdata", 64'(bus.ram_wdata), 64'(32'hA0 + i));
            cyc();
        end
        bus.wr_valid = 1'b0;
        chk("wr_done",      64'(bus.done),      64'd1);
        chk("wr_done_err",  64'(bus.err),       64'd0);
        chk("wr_done_cmdr", 64'(bus.cmd_ready), 64'd0);
        chk("wr_we_count",  64'(we_cnt - we0),  64'd4);
        for (int i = 0; i < 4; i++) chk("wr_mem", 64'(mem[5 + i]), 64'(32'hA0 + i));
        cyc();
        chk("wr_done_off",  64'(bus.done),      64'd0);
        chk("wr_idle_cmdr", 64'(bus.cmd_ready), 64'd1);

        // Read burst addr=5 len=4; wr_valid asserted but must be ignored
        cmd(1'b0, 7'd5, 7'd4);
        bus.rd_ready = 1'b1;
        bus.wr_valid = 1'b1;
        #1;
        chk("rd_first_invalid", 64'(bus.rd_valid), 64'd0);
        chk("rd_no_we",         64'(bus.ram_we),   64'd0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("rd_valid", 64'(bus.rd_valid), 64'd1);
            chk("rd_data",  64'(bus.rd_data),  64'(32'hA0 + i));
            chk("rd_done_early", 64'(bus.done), 64'd0);
            cyc();
        end
        chk("rd_done",       64'(bus.done),     64'd1);
        chk("rd_done_valid", 64'(bus.rd_valid), 64'd0);
        bus.rd_ready = 1'b0;
        bus.wr_valid = 1'b0;
        cyc();
        chk("rd_done_off", 64'(bus.done), 64'd0);

        // Wrapping write addr=46 len=4 with one bubble
        wa.delete();
        wd.delete();
        wpat = 5'b11011;
        b = 0;
        cmd(1'b1, 7'd46, 7'd4);
        for (int k = 0; k < 5; k++) begin
            bus.wr_valid = wpat[k];
            bus.wr_data  = 32'(32'hB0 + b);
            #1;
            chk("wrap_we", 64'(bus.ram_we), 64'(wpat[k]));
            if (wpat[k]) b++;
            cyc();
        end
        bus.wr_valid = 1'b0;
        chk("wrap_done", 64'(bus.done), 64'd1);
        chk("wrap_nwrites", 64'(wa.size()), 64'd4);
        if (wa.size() == 4) begin
            chk("wrap_a0", 64'(wa[0]), 64'd46);
            chk("wrap_a1", 64'(wa[1]), 64'd47);
            chk("wrap_a2", 64'(wa[2]), 64'd0);
            chk("wrap_a3", 64'(wa[3]), 64'd1);
            for (int i = 0; i < 4; i++) chk("wrap_wd", 64'(wd[i]), 64'(32'hB0 + i));
        end
        cyc();

        // Read back the wrapped range
        cmd(1'b0, 7'd46, 7'd4);
        bus.rd_ready = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("wraprd_valid", 64'(bus.rd_valid), 64'd1);
            chk("wraprd_data",  64'(bus.rd_data),  64'(32'hB0 + i));
            cyc();
        end
        chk("wraprd_done", 64'(bus.done), 64'd1);
        bus.rd_ready = 1'b0;
        cyc();

        // Backpressure read addr=5 len=3, rd_ready 1,0,0,1,1 from first valid cycle
        beats.delete();
        rdy = 5'b11001;
        bp_exp[0] = 32'hA0;
        bp_exp[1] = 32'hA1;
        bp_exp[2] = 32'hA1;
        bp_exp[3] = 32'hA1;
        bp_exp[4] = 32'hA2;
        cmd(1'b0, 7'd5, 7'd3);
        cyc();
        for (int k = 0; k < 5; k++) begin
            bus.rd_ready = rdy[k];
            #1;
            chk("bp_valid", 64'(bus.rd_valid), 64'd1);
            chk("bp_data",  64'(bus.rd_data),  64'(bp_exp[k]));
            if (bus.rd_valid && bus.rd_ready) beats.push_back(bus.rd_data);
            cyc();
        end
        bus.rd_ready = 1'b0;
        chk("bp_done",   64'(bus.done),      64'd1);
        chk("bp_nbeats", 64'(beats.size()),  64'd3);
        if (beats.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("bp_beat", 64'(beats[i]), 64'(32'hA0 + i));
        end
        cyc();

        // Rejected commands
        ra[0] = 7'd48; rl[0] = 7'd1;
        ra[1] = 7'd0;  rl[1] = 7'd0;
        ra[2] = 7'd0;  rl[2] = 7'd49;
        for (int j = 0; j < 3; j++) begin
            we0 = we_cnt;
            cmd(1'b1, ra[j], rl[j]);
            chk("rej_done", 64'(bus.done),      64'd1);
            chk("rej_err",  64'(bus.err),       64'd1);
            chk("rej_cmdr", 64'(bus.cmd_ready), 64'd1);
            cyc();
            chk("rej_done_off", 64'(bus.done), 64'd0);
            chk("rej_err_off",  64'(bus.err),  64'd0);
            chk("rej_no_write", 64'(we_cnt - we0), 64'd0);
        end

        // Reset during a 5-word read after two beats consumed
        cmd(1'b0, 7'd5, 7'd5);
        bus.rd_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("mid_valid", 64'(bus.rd_valid), 64'd1);
        chk("mid_data",  64'(bus.rd_data),  64'hA2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.rd_valid),  64'd0);
        chk("mid_rst_cmdr",  64'(bus.cmd_ready), 64'd1);
        chk("mid_rst_addr",  64'(bus.ram_addr),  64'd0);
        cyc();
        rst_n = 1'b1;
        bus.rd_ready = 1'b0;
        cyc();
        chk("mid_no_done", 64'(bus.done), 64'd0);
        cmd(1'b0, 7'd46, 7'd2);
        bus.rd_ready = 1'b1;
        #1;
        chk("post_first_invalid", 64'(bus.rd_valid), 64'd0);
        cyc();
        chk("post_valid0", 64'(bus.rd_valid), 64'd1);
        chk("post_data0",  64'(bus.rd_data),  64'hB0);
        cyc();
        chk("post_data1",  64'(bus.rd_data),  64'hB1);
        cyc();
        chk("post_done",   64'(bus.done),     64'd1);
        bus.rd_ready = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
